// File: rtl/tiny_cpu_pkg.sv
// tiny_cpu_pkg: shared constants for the tiny accumulator CPU.
// Holds the instruction class codes, the class-0 sub-op codes (including the
// halt encoding) and the control FSM state type.
package tiny_cpu_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DIV  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    // Instruction classes (upper nibble of the instruction)
    localparam logic [3:0] CL_SYS = 4'h0;
    localparam logic [3:0] CL_ADD = 4'h1;
    localparam logic [3:0] CL_SUB = 4'h2;
    localparam logic [3:0] CL_MUL = 4'h3;
    localparam logic [3:0] CL_DIV = 4'h4;
    localparam logic [3:0] CL_AND = 4'h5;
    localparam logic [3:0] CL_XOR = 4'h6;
    localparam logic [3:0] CL_CMP = 4'h7;
    localparam logic [3:0] CL_JMP = 4'h8;
    localparam logic [3:0] CL_LDA = 4'h9;
    localparam logic [3:0] CL_STA = 4'hA;
    localparam logic [3:0] CL_BCS = 4'hB;

    // Class-0 sub-ops, selected by the operand field
    localparam int unsigned OP_LSL  = 1;
    localparam int unsigned OP_LSR  = 2;
    localparam int unsigned OP_ROR  = 3;
    localparam int unsigned OP_ROL  = 4;
    localparam int unsigned OP_ASR  = 5;
    localparam int unsigned OP_INC  = 6;
    localparam int unsigned OP_DEC  = 7;
    localparam int unsigned OP_HALT = 15;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle.
// Ports: clk, rst_n (async active-low), start_i loads operands,
// dividend_i/divisor_i operands, done_c high during the final iteration
// cycle, quot_c/rem_c valid while done_c is high. Divide by zero yields
// quotient all-ones and remainder = dividend.
module seq_divider #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              done_c,
    output logic [DATA_W-1:0] quot_c,
    output logic [DATA_W-1:0] rem_c
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] rem_q, quo_q, dvs_q, dvd_q;
    logic              dz_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DATA_W:0]   trial_c;
    logic              fits_c;
    logic [DATA_W-1:0] rem_nx_c, quo_nx_c;

    // One restoring step: shift in next dividend bit, subtract if it fits
    always_comb begin
        trial_c  = {rem_q, quo_q[DATA_W-1]};
        fits_c   = (trial_c >= {1'b0, dvs_q});
        rem_nx_c = fits_c ? DATA_W'(trial_c - {1'b0, dvs_q}) : trial_c[DATA_W-1:0];
        quo_nx_c = {quo_q[DATA_W-2:0], fits_c};
    end

    // Results are the next-step values so the caller can capture on the last edge
    assign done_c = (cnt_q == CNT_W'(1));
    assign quot_c = dz_q ? '1    : quo_nx_c;
    assign rem_c  = dz_q ? dvd_q : rem_nx_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            dvd_q <= '0;
            dz_q  <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
            dvd_q <= dividend_i;
            dz_q  <= (divisor_i == '0);
            cnt_q <= CNT_W'(DATA_W);
        end else if (cnt_q != '0) begin
            rem_q <= rem_nx_c;
            quo_q <= quo_nx_c;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/tiny_acc_cpu.sv
// tiny_acc_cpu: accumulator CPU with register file, loadable imem and
// an iterative divider.
// Ports: clk, pc_reset (async assert, sync release), start, load_we/load_sel/
// load_addr/load_data (program/register loading while not busy), reg_num
// (readback select), out (registered readback), ACC, pc, busy, halted.
module tiny_acc_cpu
    import tiny_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned PC_W   = 4
) (
    input  logic                                   clk,
    input  logic                                   pc_reset,
    input  logic                                   start,
    input  logic                                   load_we,
    input  logic                                   load_sel,
    input  logic [((PC_W > REG_AW) ? PC_W : REG_AW)-1:0] load_addr,
    input  logic [4+REG_AW-1:0]                    load_data,
    input  logic [REG_AW:0]                        reg_num,
    output logic [DATA_W-1:0]                      out,
    output logic [DATA_W-1:0]                      ACC,
    output logic [PC_W-1:0]                        pc,
    output logic                                   busy,
    output logic                                   halted
);
    localparam int unsigned IW   = 4 + REG_AW;
    localparam int unsigned NREG = 2 ** REG_AW;
    localparam int unsigned NIM  = 2 ** PC_W;
    localparam int unsigned AW1  = DATA_W + 1;
    localparam int unsigned PW   = 2 * DATA_W;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d, ext_q, ext_d, out_q, out_d;
    logic              cb_q, cb_d, busy_q, halted_q, rst_sync_q, rst_n;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [IW-1:0]     imem_q [NIM];

    logic              rf_we_c, im_we_c, div_start_c, div_done_c;
    logic [REG_AW-1:0] rf_wa_c;
    logic [DATA_W-1:0] rf_wd_c, div_quot_c, div_rem_c;

    // Reset asserts immediately, releases on the next clk edge
    always_ff @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) rst_sync_q <= 1'b0;
        else           rst_sync_q <= 1'b1;
    end
    assign rst_n = rst_sync_q;

    // Fetch/decode
    logic [IW-1:0]     inst_c;
    logic [3:0]        cls_c;
    logic [REG_AW-1:0] fld_c;
    logic [DATA_W-1:0] rf_c;
    assign inst_c = imem_q[pc_q];
    assign cls_c  = inst_c[IW-1 -: 4];
    assign fld_c  = inst_c[REG_AW-1:0];
    assign rf_c   = regs_q[fld_c];

    seq_divider #(.DATA_W(DATA_W)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start_c),
        .dividend_i (acc_q),
        .divisor_i  (rf_c),
        .done_c     (div_done_c),
        .quot_c     (div_quot_c),
        .rem_c      (div_rem_c)
    );

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ext_d       = ext_q;
        cb_d        = cb_q;
        pc_d        = pc_q;
        rf_we_c     = 1'b0;
        rf_wa_c     = '0;
        rf_wd_c     = '0;
        im_we_c     = 1'b0;
        div_start_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (load_we) begin
                    if (load_sel) begin
                        rf_we_c = 1'b1;
                        rf_wa_c = load_addr[REG_AW-1:0];
                        rf_wd_c = load_data[DATA_W-1:0];
                    end else begin
                        im_we_c = 1'b1;
                    end
                end
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            ST_RUN: begin
                pc_d = pc_q + PC_W'(1);
                case (cls_c)
                    CL_SYS: begin
                        case (fld_c)
                            REG_AW'(OP_LSL): acc_d = {acc_q[DATA_W-2:0], 1'b0};
                            REG_AW'(OP_LSR): acc_d = {1'b0, acc_q[DATA_W-1:1]};
                            REG_AW'(OP_ROR): acc_d = {acc_q[0], acc_q[DATA_W-1:1]};
                            REG_AW'(OP_ROL): acc_d = {acc_q[DATA_W-2:0], acc_q[DATA_W-1]};
                            REG_AW'(OP_ASR): acc_d = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
                            REG_AW'(OP_INC): {cb_d, acc_d} = {1'b0, acc_q} + AW1'(1);
                            REG_AW'(OP_DEC): begin
                                cb_d  = (acc_q == '0);
                                acc_d = acc_q - DATA_W'(1);
                            end
                            REG_AW'(OP_HALT): begin
                                state_d = ST_HALT;
                                pc_d    = pc_q;
                            end
                            default: ;
                        endcase
                    end
                    CL_ADD: {cb_d, acc_d} = {1'b0, acc_q} + {1'b0, rf_c};
                    CL_SUB: begin
                        cb_d  = (acc_q < rf_c);
                        acc_d = acc_q - rf_c;
                    end
                    CL_MUL: {ext_d, acc_d} = PW'(acc_q) * PW'(rf_c);
                    CL_DIV: begin
                        div_start_c = 1'b1;
                        state_d     = ST_DIV;
                        pc_d        = pc_q;
                    end
                    CL_AND: acc_d = acc_q & rf_c;
                    CL_XOR: acc_d = acc_q ^ rf_c;
                    CL_CMP: cb_d  = (acc_q < rf_c);
                    CL_JMP: pc_d  = fld_c[PC_W-1:0];
                    CL_LDA: acc_d = rf_c;
                    CL_STA: begin
                        rf_we_c = 1'b1;
                        rf_wa_c = fld_c;
                        rf_wd_c = acc_q;
                    end
                    CL_BCS: if (cb_q) pc_d = fld_c[PC_W-1:0];
                    default: ;
                endcase
            end
            ST_DIV: begin
                if (div_done_c) begin
                    acc_d   = div_quot_c;
                    ext_d   = div_rem_c;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Readback mux, sampled from pre-update state
    always_comb begin
        out_d = '0;
        if (!reg_num[REG_AW])                       out_d = regs_q[reg_num[REG_AW-1:0]];
        else if (reg_num[REG_AW-1:0] == '0)         out_d = ext_q;
        else if (reg_num[REG_AW-1:0] == REG_AW'(1)) out_d = DATA_W'(cb_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            ext_q    <= '0;
            cb_q     <= 1'b0;
            pc_q     <= '0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            ext_q    <= ext_d;
            cb_q     <= cb_d;
            pc_q     <= pc_d;
            out_q    <= out_d;
            busy_q   <= (state_d == ST_RUN) || (state_d == ST_DIV);
            halted_q <= (state_d == ST_HALT);
        end
    end

    // Register file, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
        end else if (rf_we_c) begin
            regs_q[rf_wa_c] <= rf_wd_c;
        end
    end

    // Instruction memory keeps its contents across reset
    always_ff @(posedge clk) begin
        if (im_we_c && rst_n) imem_q[load_addr[PC_W-1:0]] <= load_data;
    end

    assign out    = out_q;
    assign ACC    = acc_q;
    assign pc     = pc_q;
    assign busy   = busy_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_tiny_acc_cpu.sv
// tb_tiny_acc_cpu: directed program checks plus randomized run against an
// instruction-level reference model of the accumulator CPU.
module tb_tiny_acc_cpu;
    logic       clk = 1'b0;
    logic       pc_reset, start, load_we, load_sel;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic [4:0] reg_num;
    logic [7:0] out, ACC;
    logic [3:0] pc;
    logic       busy, halted;

    tiny_acc_cpu #(.DATA_W(8), .REG_AW(4), .PC_W(4)) dut (
        .clk(clk), .pc_reset(pc_reset), .start(start), .load_we(load_we),
        .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
        .reg_num(reg_num), .out(out), .ACC(ACC), .pc(pc), .busy(busy),
        .halted(halted)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: 0 idle, 1 run, 2 div, 3 halt
    int m_st, m_acc, m_ext, m_cb, m_pc, m_out, m_cnt, m_dvd, m_dvs;
    bit m_rsync;
    int m_reg [16];
    int m_im  [16];

    task automatic check(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_acc = 0; m_ext = 0; m_cb = 0; m_pc = 0; m_out = 0;
        m_cnt = 0; m_rsync = 1'b0;
        for (int i = 0; i < 16; i++) m_reg[i] = 0;
    endtask

    task automatic model_step();
        int ins, cl, f, r, t, npc, nout, rn;
        if (!pc_reset) begin model_reset(); return; end
        if (!m_rsync) begin model_reset(); m_rsync = 1'b1; return; end
        rn   = int'(reg_num);
        nout = (rn < 16) ? m_reg[rn] : (rn == 16) ? m_ext : (rn == 17) ? m_cb : 0;
        case (m_st)
            0, 3: begin
                if (load_we) begin
                    if (load_sel) m_reg[load_addr] = int'(load_data);
                    else          m_im[load_addr]  = int'(load_data);
                end
                if (start) begin m_st = 1; m_pc = 0; end
            end
            1: begin
                ins = m_im[m_pc]; cl = ins >> 4; f = ins & 15; r = m_reg[f];
                npc = (m_pc + 1) % 16;
                case (cl)
                    0: case (f)
                        1: m_acc = (m_acc << 1) & 255;
                        2: m_acc = m_acc >> 1;
                        3: m_acc = (m_acc >> 1) | ((m_acc & 1) << 7);
                        4: m_acc = ((m_acc << 1) | (m_acc >> 7)) & 255;
                        5: m_acc = (m_acc >> 1) | (m_acc & 128);
                        6: begin t = m_acc + 1; m_cb = int'(t > 255); m_acc = t & 255; end
                        7: begin m_cb = int'(m_acc == 0); m_acc = (m_acc + 255) & 255; end
                        15: begin m_st = 3; npc = m_pc; end
                        default: ;
                    endcase
                    1: begin t = m_acc + r; m_cb = t >> 8; m_acc = t & 255; end
                    2: begin m_cb = int'(m_acc < r); m_acc = (m_acc - r + 256) & 255; end
                    3: begin t = m_acc * r; m_acc = t & 255; m_ext = t >> 8; end
                    4: begin m_st = 2; m_cnt = 8; m_dvd = m_acc; m_dvs = r; npc = m_pc; end
                    5: m_acc = m_acc & r;
                    6: m_acc = m_acc ^ r;
                    7: m_cb = int'(m_acc < r);
                    8: npc = f;
                    9: m_acc = r;
                    10: m_reg[f] = m_acc;
                    11: if (m_cb != 0) npc = f;
                    default: ;
                endcase
                m_pc = npc;
            end
            2: begin
                m_cnt--;
                if (m_cnt == 0) begin
                    if (m_dvs == 0) begin m_acc = 255; m_ext = m_dvd; end
                    else begin m_acc = m_dvd / m_dvs; m_ext = m_dvd % m_dvs; end
                    m_pc = (m_pc + 1) % 16;
                    m_st = 1;
                end
            end
            default: ;
        endcase
        m_out = nout;
    endtask

    // Cycle compare against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("cyc_acc",    ACC,    m_acc);
            check("cyc_pc",     pc,     m_pc);
            check("cyc_busy",   busy,   int'(m_st == 1 || m_st == 2));
            check("cyc_halted", halted, int'(m_st == 3));
            check("cyc_out",    out,    m_out);
        end
    end

    task automatic tick(input bit st, input bit we, input bit sel,
                        input int addr, input int data, input int rn);
        start = st; load_we = we; load_sel = sel;
        load_addr = 4'(addr); load_data = 8'(data); reg_num = 5'(rn);
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int rn);
        tick(1'b0, 1'b0, 1'b0, 0, 0, rn);
    endtask

    task automatic put_im(input int a, input int d);
        tick(1'b0, 1'b1, 1'b0, a, d, 0);
    endtask

    task automatic put_rg(input int a, input int d);
        tick(1'b0, 1'b1, 1'b1, a, d, 0);
    endtask

    task automatic run_until_halt(output int cyc);
        tick(1'b1, 1'b0, 1'b0, 0, 0, 0);
        cyc = 0;
        while (!halted && cyc < 200) begin idle(0); cyc++; end
        check("halt_reached", halted, 1);
    endtask

    task automatic do_reset();
        pc_reset = 1'b0;
        model_reset();
        idle(0);
        pc_reset = 1'b1;
        idle(0);
    endtask

    function automatic int rand_inst();
        if ($urandom_range(0, 5) == 0) return 'h0F;
        return int'($urandom_range(0, 255));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        pc_reset = 1'b0; start = 1'b0; load_we = 1'b0; load_sel = 1'b0;
        load_addr = '0; load_data = '0; reg_num = '0;
        model_reset();
        repeat (3) idle(0);
        chk_en = 1'b1;
        check("rst_acc", ACC, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_out", out, 0);
        pc_reset = 1'b1;
        idle(0);
        for (int i = 0; i < 16; i++) put_im(i, 'h0F);

        // ACC = R5 - R3, stored to R9
        put_rg(3, 2); put_rg(5, 5);
        put_im(0, 'h95); put_im(1, 'h23); put_im(2, 'hA9); put_im(3, 'h0F);
        run_until_halt(n);
        check("p1_cycles", n, 4);
        check("p1_acc", ACC, 3);
        check("p1_pc", pc, 3);
        idle(9);
        check("p1_r9", out, 3);

        // 20 / 3 with busy span
        put_rg(4, 20); put_rg(3, 3);
        put_im(0, 'h94); put_im(1, 'h43); put_im(2, 'h0F);
        tick(1'b1, 1'b0, 1'b0, 0, 0, 0);
        n = 0;
        while (busy && n < 100) begin n++; idle(0); end
        check("div_busy_span", n, 11);
        check("div_acc", ACC, 6);
        check("div_halted", halted, 1);
        idle(16);
        check("div_ext", out, 2);

        // Divide by zero
        put_rg(0, 0); put_im(1, 'h40);
        run_until_halt(n);
        check("dz_acc", ACC, 255);
        idle(16);
        check("dz_ext", out, 20);

        // Carry out of inc and conditional branch
        put_rg(1, 'hFF);
        put_im(0, 'h91); put_im(1, 'h06); put_im(2, 'hB4); put_im(3, 'h0F); put_im(4, 'h0F);
        run_until_halt(n);
        check("bcs_acc", ACC, 0);
        check("bcs_pc", pc, 4);
        idle(17);
        check("bcs_cb", out, 1);
        put_rg(1, 'h10);
        run_until_halt(n);
        check("bnc_acc", ACC, 'h11);
        check("bnc_pc", pc, 3);
        idle(17);
        check("bnc_cb", out, 0);

        // Reset in the middle of a division, then rerun
        put_im(0, 'h94); put_im(1, 'h43); put_im(2, 'h0F);
        tick(1'b1, 1'b0, 1'b0, 0, 0, 0);
        repeat (5) idle(0);
        check("mid_div_busy", busy, 1);
        pc_reset = 1'b0;
        model_reset();
        #1;
        check("arst_acc", ACC, 0);
        check("arst_busy", busy, 0);
        check("arst_out", out, 0);
        idle(16);
        idle(16);
        pc_reset = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 0, 0, 16);
        check("sync_first_start_ignored", busy, 0);
        tick(1'b1, 1'b0, 1'b0, 0, 0, 16);
        check("sync_second_start", busy, 1);
        check("arst_ext", out, 0);
        n = 0;
        while (!halted && n < 100) begin idle(0); n++; end
        check("zero_regs_halt", halted, 1);
        put_rg(4, 20); put_rg(3, 3);
        run_until_halt(n);
        check("rerun_acc", ACC, 6);

        // Endless inc program: pc wraps, loads ignored while busy
        for (int i = 0; i < 16; i++) put_im(i, 'h06);
        tick(1'b1, 1'b0, 1'b0, 0, 0, 2);
        check("wrap_start_pc", pc, 0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 3)      tick(1'b1, 1'b1, 1'b0, 0, 'h0F, 2);
            else if (i == 5) tick(1'b0, 1'b1, 1'b1, 2, 'h55, 2);
            else             idle(2);
            if (i == 15) check("wrap_pc15", pc, 15);
        end
        check("wrap_pc0", pc, 0);
        check("wrap_acc", ACC, 22);
        check("wrap_busy", busy, 1);
        idle(2);
        check("busy_reg_load_ignored", out, 0);
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle(0);
        check("busy_imem_load_ignored", ACC, 1);
        check("imem_kept_halted", halted, 0);

        // Randomized run
        do_reset();
        for (int i = 0; i < 16; i++) put_im(i, rand_inst());
        for (int i = 0; i < 16; i++) put_rg(i, int'($urandom_range(0, 255)));
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                pc_reset = 1'b0;
                model_reset();
                idle(int'($urandom_range(0, 31)));
                pc_reset = 1'b1;
            end
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 rand_inst(), int'($urandom_range(0, 31)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
